mod_dp: RTL

Datapath for the iterative modulo unit. It sits directly downstream of the modulo control FSM: it consumes that FSM's registered `write_temp` / `write_result` strobes and returns the `in_lt` status it branches on. It reduces operand `in_a` by repeated subtraction of `in_b` and counts the subtractions, so it yields both `a mod b` and `a / b`. It also resolves the one-cycle lag between the registered strobes and the status they depend on, and guards against `b == 0`.

---
 rtl/mod_pkg.sv | 15 +
 rtl/mod_sub_cmp.sv | 21 ++
 rtl/mod_dp.sv | 70 +++++++
 3 files changed

// File: rtl/mod_pkg.sv
// Shared definitions for the iterative modulo unit: word width, word type and
// the control FSM state encoding.
package mod_pkg;

  localparam int unsigned MOD_WIDTH = 32;

  typedef logic [MOD_WIDTH-1:0] mod_word_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } mod_state_t;

endpackage

// File: rtl/mod_sub_cmp.sv
// Combinational subtract-and-compare: computes cur - in_b and whether the value
// the working register will hold after a pending subtract is below in_b.
module mod_sub_cmp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] in_b,
  input  logic             write_temp,
  output logic [WIDTH-1:0] diff,
  output logic             lt
);

  logic [WIDTH-1:0] nxt;

  always_comb begin
    diff = cur - in_b;
    nxt  = write_temp ? diff : cur;
    lt   = (nxt < in_b);
  end

endmodule

// File: rtl/mod_dp.sv
// Datapath of the iterative modulo unit: repeated subtraction of in_b from in_a
// under control-FSM strobes, yielding remainder, quotient and a b==0 flag.
module mod_dp
  import mod_pkg::*;
#(
  parameter int unsigned WIDTH = MOD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             write_temp,
  input  logic             write_result,
  output logic             in_lt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] quotient,
  output logic             done,
  output logic             div_zero
);

  logic [WIDTH-1:0] temp;
  logic             loaded;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] diff;
  logic             lt;
  logic             div_zero_now;
  logic             sub_en;
  logic             cap_en;

  // Until the first subtract the dividend is used directly, avoiding a load cycle.
  always_comb begin
    cur          = loaded ? temp : in_a;
    div_zero_now = (in_b == '0);
    cap_en       = write_result & ~done;
    sub_en       = write_temp & ~write_result & ~done;
  end

  mod_sub_cmp #(
    .WIDTH(WIDTH)
  ) u_sub_cmp (
    .cur       (cur),
    .in_b      (in_b),
    .write_temp(write_temp),
    .diff      (diff),
    .lt        (lt)
  );

  // Strobes lag status by one cycle, so status looks ahead past the pending subtract.
  assign in_lt = lt | div_zero_now;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp     <= '0;
      loaded   <= 1'b0;
      result   <= '0;
      quotient <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else if (cap_en) begin
      result   <= cur;
      done     <= 1'b1;
      div_zero <= div_zero_now;
    end else if (sub_en) begin
      temp     <= diff;
      loaded   <= 1'b1;
      quotient <= quotient + WIDTH'(1);
    end
  end

endmodule
